// File: rtl/xor_rr_arbiter.sv
// Two-port round-robin front end sharing one XOR unit; operands and result are
// registered, and each port keeps a saturating accept counter.

module xor_rr_xor_unit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);
  assign y_o = a_i ^ b_i;
endmodule

// state | meaning
// IDLE  | no request in flight, either port may be accepted
// EXEC  | operands registered, shared XOR result is captured this cycle
// RESP  | result presented; a new request may be accepted as it is consumed
module xor_rr_arbiter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
  output logic             busy,
  output logic [CNT_W-1:0] acc0_cnt,
  output logic [CNT_W-1:0] acc1_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             op_id_q, op_id_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_id_q, res_id_d;
  logic             res_valid_q, res_valid_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] acc0_q, acc0_d;
  logic [CNT_W-1:0] acc1_q, acc1_d;

  logic             grant0, grant1;
  logic             accept_ok;
  logic             acc0_fire, acc1_fire, accept;
  logic [WIDTH-1:0] xor_y;

  // A contested cycle goes to the port that did not win last time.
  assign grant0    = req0_valid & (~req1_valid | last_grant_q);
  assign grant1    = req1_valid & (~req0_valid | ~last_grant_q);
  assign accept_ok = (state_q == IDLE) | ((state_q == RESP) & res_ready);

  assign req0_ready = grant0 & accept_ok;
  assign req1_ready = grant1 & accept_ok;
  assign acc0_fire  = req0_valid & req0_ready;
  assign acc1_fire  = req1_valid & req1_ready;
  assign accept     = acc0_fire | acc1_fire;

  xor_rr_xor_unit #(.WIDTH(WIDTH)) u_xor (
    .a_i (op_a_q),
    .b_i (op_b_q),
    .y_o (xor_y)
  );

  always_comb begin
    state_d      = state_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_id_d      = op_id_q;
    res_data_d   = res_data_q;
    res_id_d     = res_id_q;
    res_valid_d  = res_valid_q;
    last_grant_d = last_grant_q;
    acc0_d       = acc0_q;
    acc1_d       = acc1_q;

    case (state_q)
      IDLE: begin
        if (accept) state_d = EXEC;
      end
      EXEC: begin
        res_data_d  = xor_y;
        res_id_d    = op_id_q;
        res_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = accept ? EXEC : IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        res_valid_d = 1'b0;
      end
    endcase

    if (accept) begin
      op_a_d       = acc1_fire ? req1_a : req0_a;
      op_b_d       = acc1_fire ? req1_b : req0_b;
      op_id_d      = acc1_fire;
      last_grant_d = acc1_fire;
    end

    if (acc0_fire && (acc0_q != CNT_MAX)) acc0_d = acc0_q + CNT_ONE;
    if (acc1_fire && (acc1_q != CNT_MAX)) acc1_d = acc1_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_id_q      <= 1'b0;
      res_data_q   <= '0;
      res_id_q     <= 1'b0;
      res_valid_q  <= 1'b0;
      last_grant_q <= 1'b1;
      acc0_q       <= '0;
      acc1_q       <= '0;
    end else begin
      state_q      <= state_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_id_q      <= op_id_d;
      res_data_q   <= res_data_d;
      res_id_q     <= res_id_d;
      res_valid_q  <= res_valid_d;
      last_grant_q <= last_grant_d;
      acc0_q       <= acc0_d;
      acc1_q       <= acc1_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign busy      = (state_q != IDLE);
  assign acc0_cnt  = acc0_q;
  assign acc1_cnt  = acc1_q;

endmodule

// File: tb/tb_xor_rr_arbiter.sv
// Bench for xor_rr_arbiter: directed scenarios plus randomized traffic, all
// outputs compared every cycle against a transaction-level model.

module tb_xor_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0, res_ready = 1'b0;
  logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic       req0_ready, req1_ready, res_valid, res_id, busy;
  logic [3:0] res_data;
  logic [7:0] acc0_cnt, acc1_cnt;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // model: phase 0 = nothing in flight, 1 = computing, 2 = result on offer
  int         m_phase;
  logic [3:0] m_pend, m_data;
  logic       m_pid, m_id, m_valid, m_last;
  int         m_cnt0, m_cnt1;

  int q_id[$];
  int q_data[$];
  int q_cyc[$];

  bit hold0, hold1;
  logic [7:0] pv;

  xor_rr_arbiter #(.WIDTH(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_id     (res_id),
    .busy       (busy),
    .acc0_cnt   (acc0_cnt),
    .acc1_cnt   (acc1_cnt)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, int got, int exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got=%0d want=%0d t=%0t", name, got, exp, $time);
    end
  endfunction

  function automatic int pick(logic v0, logic v1, logic last);
    if (v0 && v1) return last ? 0 : 1;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  function automatic void m_reset();
    m_phase = 0;
    m_pend  = '0;
    m_data  = '0;
    m_pid   = 1'b0;
    m_id    = 1'b0;
    m_valid = 1'b0;
    m_last  = 1'b1;
    m_cnt0  = 0;
    m_cnt1  = 0;
  endfunction

  // compare process
  initial begin
    int  gp, acc_p;
    bit  e_ok, e_r0, e_r1;
    m_reset();
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) m_reset();
      gp   = pick(req0_valid, req1_valid, m_last);
      e_ok = (m_phase == 0) || (m_phase == 2 && res_ready);
      e_r0 = e_ok && (gp == 0);
      e_r1 = e_ok && (gp == 1);
      chk("req0_ready", int'(req0_ready), int'(e_r0));
      chk("req1_ready", int'(req1_ready), int'(e_r1));
      chk("res_valid", int'(res_valid), int'(m_valid));
      chk("res_data", int'(res_data), int'(m_data));
      chk("res_id", int'(res_id), int'(m_id));
      chk("busy", int'(busy), (m_phase != 0) ? 1 : 0);
      chk("acc0_cnt", int'(acc0_cnt), m_cnt0);
      chk("acc1_cnt", int'(acc1_cnt), m_cnt1);
      if (rst_n) begin
        if (res_valid && res_ready) begin
          q_id.push_back(int'(res_id));
          q_data.push_back(int'(res_data));
          q_cyc.push_back(cyc);
        end
        acc_p = e_r0 ? 0 : (e_r1 ? 1 : -1);
        case (m_phase)
          1: begin
            m_valid = 1'b1;
            m_data  = m_pend;
            m_id    = m_pid;
            m_phase = 2;
          end
          2: begin
            if (res_ready) begin
              m_valid = 1'b0;
              m_phase = (acc_p >= 0) ? 1 : 0;
            end
          end
          default: m_phase = (acc_p >= 0) ? 1 : 0;
        endcase
        if (acc_p == 0) begin
          m_pend = req0_a ^ req0_b;
          m_pid  = 1'b0;
          m_last = 1'b0;
          if (m_cnt0 < 255) m_cnt0++;
        end else if (acc_p == 1) begin
          m_pend = req1_a ^ req1_b;
          m_pid  = 1'b1;
          m_last = 1'b1;
          if (m_cnt1 < 255) m_cnt1++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready  = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_acc(input int p, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (p == 0) done = req0_valid && req0_ready;
      else        done = req1_valid && req1_ready;
      @(posedge clk);
      #1;
    end
    if (!done) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_results(input int n, input int budget);
    for (int i = 0; i < budget && q_id.size() < n; i++) tick();
    if (q_id.size() < n) chk("result_timeout", q_id.size(), n);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int exp_ids[6];
    exp_ids = '{0, 1, 0, 1, 0, 1};
    #1;

    // 1: single request on port 0
    apply_reset();
    chk("t1_reset_valid", int'(res_valid), 0);
    chk("t1_reset_acc0", int'(acc0_cnt), 0);
    res_ready  = 1'b1;
    req0_a     = 4'b1010;
    req0_b     = 4'b0110;
    req0_valid = 1'b1;
    wait_acc(0, 4);
    req0_valid = 1'b0;
    chk("t1_exec_valid", int'(res_valid), 0);
    chk("t1_exec_busy", int'(busy), 1);
    tick();
    chk("t1_res_valid", int'(res_valid), 1);
    chk("t1_res_data", int'(res_data), 12);
    chk("t1_res_id", int'(res_id), 0);
    chk("t1_acc0", int'(acc0_cnt), 1);
    tick();
    chk("t1_done_valid", int'(res_valid), 0);
    chk("t1_done_busy", int'(busy), 0);

    // 2: both ports held valid for six grants
    apply_reset();
    q_id.delete(); q_data.delete(); q_cyc.delete();
    res_ready  = 1'b1;
    req0_a = 4'($urandom); req0_b = 4'($urandom);
    req1_a = 4'($urandom); req1_b = 4'($urandom);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 60 && n < 6; i++) begin
      @(negedge clk);
      hold0 = req0_valid && req0_ready;
      hold1 = req1_valid && req1_ready;
      if (hold0 || hold1) n++;
      @(posedge clk);
      #1;
      if (hold0) begin req0_a = 4'($urandom); req0_b = 4'($urandom); end
      if (hold1) begin req1_a = 4'($urandom); req1_b = 4'($urandom); end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("t2_grants", n, 6);
    chk("t2_acc0", int'(acc0_cnt), 3);
    chk("t2_acc1", int'(acc1_cnt), 3);
    wait_results(6, 20);
    for (int k = 0; k < 6 && k < q_id.size(); k++) chk("t2_id_order", q_id[k], exp_ids[k]);

    // 3: consumer stalls with both ports pending
    apply_reset();
    res_ready  = 1'b0;
    req0_a     = 4'h3;
    req0_b     = 4'h5;
    req0_valid = 1'b1;
    wait_acc(0, 4);
    req0_a = 4'hA; req0_b = 4'h1;
    req1_a = 4'h9; req1_b = 4'h9;
    req1_valid = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("t3_stall_valid", int'(res_valid), 1);
      chk("t3_stall_data", int'(res_data), 6);
      chk("t3_stall_id", int'(res_id), 0);
      chk("t3_stall_ready0", int'(req0_ready), 0);
      chk("t3_stall_ready1", int'(req1_ready), 0);
      tick();
    end
    chk("t3_acc0", int'(acc0_cnt), 1);
    chk("t3_acc1", int'(acc1_cnt), 0);
    res_ready = 1'b1;
    wait_acc(1, 3);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("t3_acc1_after", int'(acc1_cnt), 1);
    repeat (3) tick();

    // 4: back-to-back on port 1
    apply_reset();
    q_id.delete(); q_data.delete(); q_cyc.delete();
    res_ready  = 1'b1;
    req1_a = 4'($urandom); req1_b = 4'($urandom);
    req1_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_acc(1, 4);
      req1_a = 4'($urandom); req1_b = 4'($urandom);
    end
    req1_valid = 1'b0;
    wait_results(5, 10);
    for (int k = 1; k < 5 && k < q_cyc.size(); k++) chk("t4_interval", q_cyc[k] - q_cyc[k-1], 2);

    // 5: reset during EXEC, then during RESP
    apply_reset();
    res_ready  = 1'b0;
    req0_a     = 4'hF;
    req0_b     = 4'hF;
    req0_valid = 1'b1;
    wait_acc(0, 4);
    req0_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t5_exec_rst_valid", int'(res_valid), 0);
    chk("t5_exec_rst_acc0", int'(acc0_cnt), 0);
    chk("t5_exec_rst_busy", int'(busy), 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("t5_exec_stale", int'(res_valid), 0);
    req0_valid = 1'b1;
    wait_acc(0, 4);
    req0_valid = 1'b0;
    tick();
    chk("t5_resp_valid", int'(res_valid), 1);
    chk("t5_resp_data", int'(res_data), 0);
    rst_n = 1'b0;
    #1;
    chk("t5_resp_rst_valid", int'(res_valid), 0);
    chk("t5_resp_rst_acc0", int'(acc0_cnt), 0);
    tick();
    rst_n     = 1'b1;
    res_ready = 1'b1;
    repeat (3) tick();
    chk("t5_resp_stale", int'(res_valid), 0);

    // 6: all 256 operand pairs on port 1
    apply_reset();
    q_id.delete(); q_data.delete(); q_cyc.delete();
    res_ready = 1'b1;
    for (int p = 0; p < 256; p++) begin
      pv         = p[7:0];
      req1_a     = pv[7:4];
      req1_b     = pv[3:0];
      req1_valid = 1'b1;
      wait_acc(1, 4);
    end
    req1_valid = 1'b0;
    repeat (3) tick();
    chk("t6_results", q_id.size(), 256);
    chk("t6_acc1_sat", int'(acc1_cnt), 255);
    chk("t6_acc0", int'(acc0_cnt), 0);

    // randomized traffic with occasional resets
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      hold0 = req0_valid && !req0_ready;
      hold1 = req1_valid && !req1_ready;
      @(posedge clk);
      #1;
      if (hold0) begin
        if ($urandom_range(7) == 0) req0_valid = 1'b0;
      end else begin
        req0_valid = ($urandom_range(1) == 1);
        req0_a     = 4'($urandom);
        req0_b     = 4'($urandom);
      end
      if (hold1) begin
        if ($urandom_range(7) == 0) req1_valid = 1'b0;
      end else begin
        req1_valid = ($urandom_range(1) == 1);
        req1_a     = 4'($urandom);
        req1_b     = 4'($urandom);
      end
      res_ready = ($urandom_range(3) != 0);
      if ($urandom_range(499) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready  = 1'b1;
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
